// File: rtl/nand_4.sv
// Vector NAND leaf: combinational y = ~(a & b) per bit, plus a registered copy
// with a valid flag and an all-zeros status flag for clocked consumers.
module nand_4 #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             out_valid,
    output logic             all_low
);

    logic [WIDTH-1:0] w_nand;
    logic [WIDTH-1:0] r_y_q;
    logic             r_out_valid;
    logic             r_all_low;

    assign w_nand = ~(a & b);
    assign y      = w_nand;

    // Reset value of y_q is the NAND of all-zero operands, so it reads as all ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_y_q       <= {WIDTH{1'b1}};
            r_all_low   <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_y_q     <= w_nand;
                r_all_low <= (w_nand == {WIDTH{1'b0}});
            end
        end
    end

    assign y_q       = r_y_q;
    assign out_valid = r_out_valid;
    assign all_low   = r_all_low;

endmodule

// File: tb/tb_nand_4.sv
// Directed bench for nand_4: combinational truth, reset, registered capture,
// hold, mid-stream reset and an exhaustive sweep of all operand pairs.
module tb_nand_4;

    logic       clk;
    logic       rst_n;
    logic [3:0] a;
    logic [3:0] b;
    logic       in_valid;
    logic [3:0] y;
    logic [3:0] y_q;
    logic       out_valid;
    logic       all_low;

    int checks = 0;
    int errors = 0;

    nand_4 #(.WIDTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .y         (y),
        .y_q       (y_q),
        .out_valid (out_valid),
        .all_low   (all_low)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic edge_step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_y;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 4'b0000;
        b        = 4'b0000;

        // Combinational truth, no clock edge needed
        #1; chk("comb_0000_0000", y, 4'b1111);
        a = 4'b1010; b = 4'b0101; #1; chk("comb_1010_0101", y, 4'b1111);
        a = 4'b1111; b = 4'b1111; #1; chk("comb_1111_1111", y, 4'b0000);
        a = 4'b1100; b = 4'b0110; #1; chk("comb_1100_0110", y, 4'b1011);

        // Reset held for two edges with valid all-ones operands
        a = 4'b1111; b = 4'b1111; in_valid = 1'b1; rst_n = 1'b0;
        for (int i = 0; i < 2; i++) begin
            edge_step();
            chk("rst_y_q", y_q, 4'b1111);
            chk("rst_out_valid", {3'b0, out_valid}, 4'd0);
            chk("rst_all_low", {3'b0, all_low}, 4'd0);
            chk("rst_y", y, 4'b0000);
        end

        // Registered path
        rst_n = 1'b1;
        edge_step();
        chk("reg1_y_q", y_q, 4'b0000);
        chk("reg1_all_low", {3'b0, all_low}, 4'd1);
        chk("reg1_out_valid", {3'b0, out_valid}, 4'd1);
        a = 4'b1100; b = 4'b0110;
        edge_step();
        chk("reg2_y_q", y_q, 4'b1011);
        chk("reg2_all_low", {3'b0, all_low}, 4'd0);
        chk("reg2_out_valid", {3'b0, out_valid}, 4'd1);

        // Hold: operands toggle with in_valid low
        in_valid = 1'b0;
        a = 4'b1111; b = 4'b1111;
        for (int i = 0; i < 3; i++) begin
            #1; chk("hold_y_track", y, ~(a & b));
            edge_step();
            chk("hold_y_q", y_q, 4'b1011);
            chk("hold_all_low", {3'b0, all_low}, 4'd0);
            chk("hold_out_valid", {3'b0, out_valid}, 4'd0);
            a = ~a; b = b ^ 4'b0101;
        end

        // Mid-cycle operand change must not disturb the registered outputs
        a = 4'b0011; b = 4'b0011; #2;
        chk("midcycle_y", y, 4'b1100);
        chk("midcycle_y_q", y_q, 4'b1011);

        // Reset mid-stream
        in_valid = 1'b1; a = 4'b1111; b = 4'b1111;
        edge_step();
        chk("mid_cap_y_q", y_q, 4'b0000);
        chk("mid_cap_all_low", {3'b0, all_low}, 4'd1);
        rst_n = 1'b0;
        edge_step();
        chk("mid_rst_y_q", y_q, 4'b1111);
        chk("mid_rst_all_low", {3'b0, all_low}, 4'd0);
        chk("mid_rst_out_valid", {3'b0, out_valid}, 4'd0);
        rst_n = 1'b1; a = 4'b1010; b = 4'b0101;
        edge_step();
        chk("post_rst_y_q", y_q, 4'b1111);
        chk("post_rst_out_valid", {3'b0, out_valid}, 4'd1);
        chk("post_rst_all_low", {3'b0, all_low}, 4'd0);

        // Exhaustive sweep, valid every cycle
        for (int i = 0; i < 256; i++) begin
            a = i[7:4];
            b = i[3:0];
            exp_y = ~(i[7:4] & i[3:0]);
            #1; chk("sweep_y", y, exp_y);
            edge_step();
            chk("sweep_y_q", y_q, exp_y);
            chk("sweep_all_low", {3'b0, all_low}, {3'b0, (exp_y == 4'b0000)});
            chk("sweep_out_valid", {3'b0, out_valid}, 4'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
